// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the default geometry, the NOP returned on a miss, the refill FSM
// state type and helpers that derive address-field widths from the geometry.
package icache_pkg;

  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned DEF_WORDS = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  function automatic int unsigned offset_width(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
    return 32 - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data storage for the instruction cache.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (valid bits only)
//   rd_index/rd_offset  combinational lookup -> rd_tag, rd_valid, rd_word
//   wr_en/wr_index/wr_offset/wr_data   single data-word write port
//   tag_wr/tag_data/set_valid          tag write, optionally marking the line valid
//   clear_all           synchronous invalidate of every line (wins over set_valid)
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [index_width(LINES)-1:0]       rd_index,
  input  logic [offset_width(WORDS)-1:0]      rd_offset,
  output logic [tag_width(LINES, WORDS)-1:0]  rd_tag,
  output logic                                rd_valid,
  output logic [31:0]                         rd_word,
  input  logic                                wr_en,
  input  logic [index_width(LINES)-1:0]       wr_index,
  input  logic [offset_width(WORDS)-1:0]      wr_offset,
  input  logic [31:0]                         wr_data,
  input  logic                                tag_wr,
  input  logic [tag_width(LINES, WORDS)-1:0]  tag_data,
  input  logic                                set_valid,
  input  logic                                clear_all
);

  localparam int unsigned TW = tag_width(LINES, WORDS);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      data [LINES*WORDS];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = data[{rd_index, rd_offset}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (tag_wr && set_valid) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (tag_wr) begin
      tags[wr_index] <= tag_data;
    end
    if (wr_en) begin
      data[{wr_index, wr_offset}] <= wr_data;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between fetch and memory.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   A             fetch byte address; RD/Ready answer it in the same cycle
//   RD, Ready     instruction word and hit flag (RD = NOP when not a hit)
//   Flush         one-cycle invalidate-all (fence.i)
//   MemReq        refill request, high for the whole burst
//   MemAddr       line-aligned refill address, stable while MemReq is high
//   MemValid      one refill beat on MemData this cycle
//   MemData       refill beat, word 0 first
module instr_cache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  output logic [31:0] RD,
  output logic        Ready,
  input  logic        Flush,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemValid,
  input  logic [31:0] MemData
);

  localparam int unsigned OW = offset_width(WORDS);
  localparam int unsigned IW = index_width(LINES);
  localparam int unsigned TW = tag_width(LINES, WORDS);
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS - 1);

  logic [OW-1:0] a_off;
  logic [IW-1:0] a_idx;
  logic [TW-1:0] a_tag;
  logic [TW-1:0] rd_tag;
  logic          rd_valid;
  logic [31:0]   rd_word;

  state_t        state, state_next;
  logic [OW-1:0] beat;
  logic          drop;
  logic [31:0]   mem_addr_q;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          last_beat;
  logic          unused_a_low;

  assign a_off        = A[OW+1:2];
  assign a_idx        = A[IW+OW+1:OW+2];
  assign a_tag        = A[31:IW+OW+2];
  assign unused_a_low = ^A[1:0];

  // The in-flight line is identified by the latched address, not by A.
  assign fill_idx  = mem_addr_q[IW+OW+1:OW+2];
  assign fill_tag  = mem_addr_q[31:IW+OW+2];
  assign last_beat = (state == REFILL) && MemValid && (beat == LAST_BEAT);

  always_comb begin
    hit        = (state == IDLE) && rd_valid && (rd_tag == a_tag);
    state_next = state;
    case (state)
      IDLE:    if (!hit && !Flush) state_next = REFILL;
      REFILL:  if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Ready   = hit;
  assign RD      = hit ? rd_word : NOP_INSTR;
  assign MemReq  = (state == REFILL);
  assign MemAddr = mem_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mem_addr_q <= '0;
      beat       <= '0;
      drop       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (!hit && !Flush) begin
          mem_addr_q <= {a_tag, a_idx, {(OW + 2){1'b0}}};
          beat       <= '0;
        end
      end else begin
        if (MemValid) begin
          beat <= beat + 1'b1;
        end
        if (last_beat) begin
          drop <= 1'b0;
        end else if (Flush) begin
          drop <= 1'b1;
        end
      end
    end
  end

  // A Flush on the final beat must also keep the line invalid, so it gates
  // set_valid directly in addition to the registered drop flag.
  icache_line_store #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (a_idx),
    .rd_offset(a_off),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_word  (rd_word),
    .wr_en    ((state == REFILL) && MemValid),
    .wr_index (fill_idx),
    .wr_offset(beat),
    .wr_data  (MemData),
    .tag_wr   (last_beat),
    .tag_data (fill_tag),
    .set_valid(!drop && !Flush),
    .clear_all(Flush)
  );

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;

  localparam int unsigned LINES      = 16;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned LINE_BYTES = 4 * WORDS;
  localparam logic [31:0] NOP        = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] RD;
  logic        Ready;
  logic        Flush;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemValid;
  logic [31:0] MemData;

  instr_cache #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .RD      (RD),
    .Ready   (Ready),
    .Flush   (Flush),
    .MemReq  (MemReq),
    .MemAddr (MemAddr),
    .MemValid(MemValid),
    .MemData (MemData)
  );

  always #5 clk = ~clk;

  // Backing memory: 1024 words, upper address bits folded in so high tags differ.
  logic [31:0] memory [1024];

  // Reference model: which line address each index holds, and the pending refill.
  bit          mvalid [LINES];
  logic [31:0] mline  [LINES];
  bit          busy;
  logic [31:0] rline;
  int          beats;
  bit          drop;
  int          wait_cnt;
  int          lat;
  int          gap_pct;
  bit          idle_junk;

  bit          seen_ready;
  bit          seen_req;
  logic [31:0] seen_rd;
  logic [31:0] seen_addr;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return memory[a[11:2]] ^ {a[31:12], 12'h000};
  endfunction

  task automatic model_reset();
    busy = 0; drop = 0; beats = 0; wait_cnt = 0;
    for (int i = 0; i < LINES; i++) mvalid[i] = 0;
  endtask

  task automatic prep_mem();
    if (busy && wait_cnt == 0 && $urandom_range(99) >= gap_pct) begin
      MemValid = 1'b1;
      MemData  = mem_word(rline + 32'(4 * beats));
    end else begin
      MemValid = (!busy && idle_junk) ? 1'($urandom_range(1)) : 1'b0;
      MemData  = $urandom;
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic run_cycle();
    logic [31:0] la;
    logic [31:0] erd;
    int ix;
    bit eh;
    la = A & ~(LINE_BYTES - 1);
    ix = int'((A / LINE_BYTES) % LINES);
    @(negedge clk);
    eh  = rst && !busy && mvalid[ix] && (mline[ix] == la);
    erd = eh ? mem_word({A[31:2], 2'b00}) : NOP;
    seen_ready = Ready; seen_rd = RD; seen_req = MemReq; seen_addr = MemAddr;
    total++;
    if (Ready !== eh) begin
      bad++; $display("FAIL ready A=%h got=%b want=%b t=%0t", A, Ready, eh, $time);
    end
    total++;
    if (RD !== erd) begin
      bad++; $display("FAIL rd A=%h got=%h want=%h t=%0t", A, RD, erd, $time);
    end
    total++;
    if (MemReq !== busy) begin
      bad++; $display("FAIL memreq got=%b want=%b t=%0t", MemReq, busy, $time);
    end
    if (busy) begin
      total++;
      if (MemAddr !== rline) begin
        bad++; $display("FAIL memaddr got=%h want=%h t=%0t", MemAddr, rline, $time);
      end
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (!busy) begin
      if (Flush) begin
        for (int i = 0; i < LINES; i++) mvalid[i] = 0;
      end else if (!eh) begin
        busy = 1; rline = la; beats = 0; drop = 0; wait_cnt = lat;
      end
    end else begin
      if (Flush) begin
        for (int i = 0; i < LINES; i++) mvalid[i] = 0;
        drop = 1;
      end
      if (MemValid) begin
        beats++;
        if (beats == WORDS) begin
          ix = int'((rline / LINE_BYTES) % LINES);
          mline[ix]  = rline;
          mvalid[ix] = !drop;
          busy = 0; drop = 0;
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
    end
    #1;
  endtask

  task automatic cyc();
    prep_mem();
    run_cycle();
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    cyc();
    while (!seen_ready && n < 40) begin
      cyc();
      n++;
    end
    total++;
    if (!seen_ready) begin
      bad++; $display("FAIL %s_timeout got ready=0 want ready=1", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; A = '0; Flush = 1'b0; MemValid = 1'b0; MemData = '0;
    lat = 2; gap_pct = 0; idle_junk = 0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    total++;
    if (Ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", Ready); end
    total++;
    if (RD !== NOP) begin bad++; $display("FAIL reset_rd got=%h want=%h", RD, NOP); end
    total++;
    if (MemReq !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b want=0", MemReq); end
    total++;
    if (MemAddr !== 32'h0) begin bad++; $display("FAIL reset_memaddr got=%h want=0", MemAddr); end
    run_cycle();
    run_cycle();
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int first;
    int reqs;
    logic [31:0] want [4];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h44;
    A = 32'h0; lat = 2; gap_pct = 0;
    first = -1; reqs = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (seen_req) reqs++;
      if (seen_ready) begin first = n; break; end
    end
    total++;
    if (first != 7) begin bad++; $display("FAIL cold_latency got=%0d want=7", first); end
    total++;
    if (reqs != 6) begin bad++; $display("FAIL cold_memreq_cycles got=%0d want=6", reqs); end
    for (int w = 0; w < 4; w++) begin
      A = 32'(4 * w);
      cyc();
      total++;
      if (!seen_ready || seen_rd !== want[w]) begin
        bad++; $display("FAIL cold_hit_word%0d got=%b/%h want=1/%h", w, seen_ready, seen_rd, want[w]);
      end
    end
  endtask

  task automatic test_conflict();
    A = 32'h100; lat = 1;
    cyc();
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL conflict_miss got=%b want=0", seen_ready); end
    cyc();
    total++;
    if (!seen_req || seen_addr !== 32'h100) begin
      bad++; $display("FAIL conflict_addr got=%b/%h want=1/00000100", seen_req, seen_addr);
    end
    wait_ready("conflict_fill");
    A = 32'h0;
    cyc();
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL conflict_evicted got=%b want=0", seen_ready); end
    wait_ready("conflict_refill");
  endtask

  task automatic test_gaps_a_change();
    bit gapped;
    int n;
    Flush = 1'b1; cyc(); Flush = 1'b0;
    A = 32'h0; lat = 1; gap_pct = 0; gapped = 0;
    cyc();
    n = 0;
    while (busy && n < 40) begin
      cyc();
      if (beats == 2 && !gapped) begin
        wait_cnt = 2; gapped = 1; A = 32'h40;
      end
      n++;
    end
    cyc();
    total++;
    if (seen_ready !== 1'b0 || seen_req !== 1'b0) begin
      bad++; $display("FAIL gap_newmiss got=%b/%b want=0/0", seen_ready, seen_req);
    end
    cyc();
    total++;
    if (!seen_req || seen_addr !== 32'h40) begin
      bad++; $display("FAIL gap_rerise got=%b/%h want=1/00000040", seen_req, seen_addr);
    end
    wait_ready("gap_fill40");
    A = 32'h0;
    cyc();
    total++;
    if (!seen_ready || seen_rd !== 32'h11) begin
      bad++; $display("FAIL gap_line0 got=%b/%h want=1/00000011", seen_ready, seen_rd);
    end
  endtask

  task automatic test_flush();
    bit done_f;
    int n;
    A = 32'h0; lat = 1;
    Flush = 1'b1; cyc(); Flush = 1'b0;
    cyc();
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b want=0", seen_ready); end
    done_f = 0; n = 0;
    while (busy && n < 40) begin
      prep_mem();
      Flush = busy && beats == 1 && !done_f;
      if (Flush) done_f = 1;
      run_cycle();
      Flush = 1'b0;
      n++;
    end
    cyc();
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL flush_refill got=%b want=0", seen_ready); end
    n = 0;
    while (busy && n < 40) begin
      prep_mem();
      Flush = busy && (beats == WORDS - 1) && MemValid;
      run_cycle();
      Flush = 1'b0;
      n++;
    end
    cyc();
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL flush_lastbeat got=%b want=0", seen_ready); end
    wait_ready("flush_recover");
  endtask

  task automatic test_reset_mid();
    int n;
    A = 32'h80; lat = 1; gap_pct = 0;
    cyc();
    n = 0;
    while (beats < 2 && n < 40) begin
      cyc();
      n++;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (MemReq !== 1'b0 || Ready !== 1'b0 || RD !== NOP) begin
      bad++; $display("FAIL midreset_outputs got=%b/%b/%h want=0/0/%h", MemReq, Ready, RD, NOP);
    end
    total++;
    if (MemAddr !== 32'h0) begin bad++; $display("FAIL midreset_addr got=%h want=0", MemAddr); end
    model_reset();
    cyc();
    rst = 1'b1;
    cyc();
    total++;
    if (seen_ready !== 1'b0) begin bad++; $display("FAIL midreset_miss got=%b want=0", seen_ready); end
    cyc();
    total++;
    if (!seen_req || seen_addr !== 32'h80) begin
      bad++; $display("FAIL midreset_restart got=%b/%h want=1/00000080", seen_req, seen_addr);
    end
    wait_ready("midreset_fill");
    total++;
    if (seen_rd !== mem_word(32'h80)) begin
      bad++; $display("FAIL midreset_data got=%h want=%h", seen_rd, mem_word(32'h80));
    end
  endtask

  task automatic test_random();
    gap_pct = 25; idle_junk = 1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) < 30) begin
        A = {($urandom_range(3) == 0) ? 1'b1 : 1'b0, 21'h0, 10'($urandom)};
      end
      lat = $urandom_range(3);
      Flush = ($urandom_range(99) < 3);
      cyc();
    end
    Flush = 1'b0; idle_junk = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) memory[i] = $urandom;
    memory[0] = 32'h11; memory[1] = 32'h22; memory[2] = 32'h33; memory[3] = 32'h44;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_gaps_a_change();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
